// File: rtl/interrupt_controller.sv
// 8-source interrupt controller with a 16-byte bus register window (ENABLE, PENDING, CLAIM, COMPLETE).
// Define INTC_ROUND_ROBIN_EN for round-robin arbitration; the default build is fixed lowest-index priority.
module interrupt_controller #(
  parameter logic [31:0] START_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  irq_in,
  output logic        cpu_irq,
  input  logic [31:0] addr_bus,
  inout  wire  [31:0] data_bus,
  input  logic        rd_bus,
  input  logic        wr_bus,
  input  logic [3:0]  data_mask_bus,
  output wire         fc_bus
);

  typedef enum logic {IDLE, DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  enable_q, enable_d;
  logic [7:0]  pending_q, pending_d;
  logic        in_service_q, in_service_d;
  logic [2:0]  in_service_idx_q, in_service_idx_d;
  logic        cpu_irq_q, cpu_irq_d;
`ifdef INTC_ROUND_ROBIN_EN
  logic [2:0]  rr_ptr_q, rr_ptr_d;
  logic [2:0]  cand_idx;
  logic        found;
`endif

  logic        hit;
  logic [1:0]  reg_idx;
  logic [7:0]  candidates;
  logic        win_valid;
  logic [2:0]  win_idx;
  logic [31:0] rdata;
  logic [7:0]  pending_clr;
  logic        do_write;
  logic        unused_bits;

  // 33-bit compare keeps the window test correct when it sits at the top of the address space
  assign hit = ({1'b0, addr_bus} >= {1'b0, START_ADDR}) &&
               ({1'b0, addr_bus} <  ({1'b0, START_ADDR} + 33'd16));
  assign reg_idx     = addr_bus[3:2];
  assign candidates  = pending_q & enable_q;
  assign unused_bits = ^{data_bus[31:8], data_mask_bus[3:1], addr_bus[1:0]};

  always_comb begin
    win_valid = |candidates;
    win_idx   = '0;
`ifdef INTC_ROUND_ROBIN_EN
    found    = 1'b0;
    cand_idx = '0;
    for (int unsigned off = 0; off < 8; off++) begin
      cand_idx = rr_ptr_q + 3'(off + 1);
      if (!found && candidates[cand_idx]) begin
        win_idx = cand_idx;
        found   = 1'b1;
      end
    end
`else
    for (int unsigned i = 8; i > 0; i--) begin
      if (candidates[i-1]) win_idx = 3'(i - 1);
    end
`endif
  end

  always_comb begin
    rdata = '0;
    case (reg_idx)
      2'd0:    rdata = {24'b0, enable_q};
      2'd1:    rdata = {24'b0, pending_q};
      2'd2:    rdata = {win_valid, 28'b0, win_idx};
      default: rdata = '0;
    endcase
  end

  assign data_bus = (hit && rd_bus) ? rdata : 'z;
  assign fc_bus   = hit ? (rd_bus || (state_q == DONE)) : 1'bz;
  assign cpu_irq  = cpu_irq_q;

  always_comb begin
    state_d          = state_q;
    enable_d         = enable_q;
    in_service_d     = in_service_q;
    in_service_idx_d = in_service_idx_q;
`ifdef INTC_ROUND_ROBIN_EN
    rr_ptr_d         = rr_ptr_q;
`endif
    pending_clr      = '0;
    do_write         = (state_q == IDLE) && hit && wr_bus;

    case (state_q)
      IDLE:    if (hit && wr_bus) state_d = DONE;
      DONE:    if (!(hit && wr_bus)) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (do_write && data_mask_bus[0]) begin
      case (reg_idx)
        2'd0: enable_d = data_bus[7:0];
        2'd1: pending_clr = data_bus[7:0];
        2'd2: begin
          if (candidates[data_bus[2:0]] && !in_service_q) begin
            pending_clr[data_bus[2:0]] = 1'b1;
            in_service_d               = 1'b1;
            in_service_idx_d           = data_bus[2:0];
`ifdef INTC_ROUND_ROBIN_EN
            rr_ptr_d                   = data_bus[2:0];
`endif
          end
        end
        default: begin
          if (in_service_q && (data_bus[2:0] == in_service_idx_q)) in_service_d = 1'b0;
        end
      endcase
    end

    // a new pulse outranks a same-cycle clear
    pending_d = (pending_q & ~pending_clr) | irq_in;
    cpu_irq_d = win_valid && !in_service_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= IDLE;
      enable_q         <= '0;
      pending_q        <= '0;
      in_service_q     <= 1'b0;
      in_service_idx_q <= '0;
      cpu_irq_q        <= 1'b0;
`ifdef INTC_ROUND_ROBIN_EN
      rr_ptr_q         <= 3'd7;
`endif
    end else begin
      state_q          <= state_d;
      enable_q         <= enable_d;
      pending_q        <= pending_d;
      in_service_q     <= in_service_d;
      in_service_idx_q <= in_service_idx_d;
      cpu_irq_q        <= cpu_irq_d;
`ifdef INTC_ROUND_ROBIN_EN
      rr_ptr_q         <= rr_ptr_d;
`endif
    end
  end

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 SHALL have parameter START_ADDR, default 32'h0, base byte address of a 16-byte register window.
REQ-002 SHALL have port clk  input  1  the single clock.
REQ-003 SHALL have port rst  input  1  reset; asynchronous and active-low.
REQ-004 SHALL have port irq_in  input  8  rising-edge-free source pulses, one per source, e.g. button irq_0..irq_3 on bits 0..3.
REQ-005 SHALL have port cpu_irq  output  1  interrupt request to the CPU.
REQ-006 SHALL have port addr_bus  input  32  bus address.
REQ-007 SHALL have port data_bus  inout  32  bus data; driven only during a read hit, else 32'bz.
REQ-008 SHALL have ports rd_bus and wr_bus  input  1 each  bus read and write strobes.
REQ-009 SHALL have port data_mask_bus  input  4  byte-lane write enables.
REQ-010 SHALL have port fc_bus  output  1  function complete; 1'bz when address misses.

Function
REQ-011 SHALL decode addr_bus: hit when START_ADDR <= addr < START_ADDR+16; reg index = addr[3:2].
REQ-012 SHALL map: 0 ENABLE (RW, bits 7:0), 1 PENDING (R, W1C bits 7:0), 2 CLAIM (R/W), 3 COMPLETE (W, reads 0).
REQ-013 SHALL honour writes only when data_mask_bus[0]=1; other lanes ignored.
REQ-014 SHALL set pending[i] on any cycle irq_in[i]=1, regardless of enable[i].
REQ-015 SHALL, when a set and a clear of pending[i] coincide in one cycle, keep pending[i]=1 (set wins).
REQ-016 SHALL compute candidates = pending & enable and select a winner per REQ-030/031.
REQ-017 SHALL read CLAIM combinationally as {valid at bit 31, 28'b0, winner index at bits 2:0}; valid=0 and index=0 when no candidate; reads have no side effects.
REQ-018 SHALL, on a CLAIM write of index k with pending[k]&enable[k]=1 and no source in service, clear pending[k], set in_service=1, in_service_idx=k.
REQ-019 SHALL ignore CLAIM writes whose index is not a candidate or while in_service=1; the bus cycle still completes.
REQ-020 SHALL, on a COMPLETE write of index equal to in_service_idx, clear in_service; mismatching index ignored.
REQ-021 SHALL drive cpu_irq = (|candidates) && !in_service, registered; asserts one cycle after the candidate appears.
REQ-022 SHALL complete reads in the request cycle: data_bus and fc_bus=1 while addr hit && rd_bus.
REQ-023 SHALL sequence writes with states IDLE and DONE: IDLE + write hit -> perform register update, go DONE; DONE drives fc_bus=1; DONE -> IDLE when write hit drops.
REQ-024 SHALL perform exactly one register update per write transaction, however long wr_bus is held.

Reset
REQ-025 SHALL on rst=0 asynchronously clear enable, pending, in_service, in_service_idx, round-robin pointer, state to IDLE.
REQ-026 SHALL hold cpu_irq=0 during and the first cycle after reset; fc_bus/data_bus follow REQ-007/010.
REQ-027 SHALL, if reset asserts mid-write (state DONE), return to IDLE with no partial update retained.
REQ-028 SHALL ignore irq_in pulses while rst=0.

Configuration
REQ-029 SHALL compile round-robin arbitration only when macro INTC_ROUND_ROBIN_EN is defined.
REQ-030 SHALL, without INTC_ROUND_ROBIN_EN, use fixed priority: lowest candidate index wins.
REQ-031 SHALL, with INTC_ROUND_ROBIN_EN, search from (last claimed index + 1) mod 8 upward with wrap; pointer updates on successful claim, reset value 7 (search starts at 0).

Verification
REQ-032 SHALL test: write ENABLE=0x0F, pulse irq_in[2] -> PENDING=0x04, CLAIM reads 0x80000002, cpu_irq=1 next cycle.
REQ-033 SHALL test: pulse irq_in[1] and irq_in[3] same cycle, ENABLE=0xFF -> CLAIM index 1 (fixed); write CLAIM=1 -> PENDING=0x08, cpu_irq=0; write COMPLETE=1 -> CLAIM index 3, cpu_irq=1.
REQ-034 SHALL test: ENABLE=0x00, pulse irq_in[0] -> PENDING=0x01, cpu_irq=0, CLAIM reads 0x00000000; write PENDING=0x01 -> PENDING=0x00.
REQ-035 SHALL test: W1C PENDING=0x10 same cycle as irq_in[4] pulse -> PENDING bit 4 remains 1.
REQ-036 SHALL test: hold wr_bus 5 cycles on CLAIM -> single claim, fc_bus=1 from cycle 2 until wr_bus drops; rst=0 mid-transaction -> all registers 0, state IDLE.
REQ-037 SHALL test with INTC_ROUND_ROBIN_EN: irq 0 and 5 pending, claim 0 and complete, re-pulse irq 0 -> next CLAIM index 5.
